// File: rtl/multicycle_main_control_pkg.sv
// mips_ctrl_pkg: shared state, opcode and select encodings for the multicycle MIPS control.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    MEM_ADDR   = 4'd2,
    MEM_READ   = 4'd3,
    MEM_WB     = 4'd4,
    MEM_WRITE  = 4'd5,
    EXECUTE    = 4'd6,
    R_COMPLETE = 4'd7,
    BRANCH     = 4'd8,
    JUMP       = 4'd9
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/multicycle_main_control_if.sv
// multicycle_main_control_if: opcode/memory handshake in, datapath strobes and selects out.
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state_dbg;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state_dbg
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: Moore FSM sequencing the multicycle MIPS datapath.
module multicycle_main_control
  import mips_ctrl_pkg::*;
(
  input logic                         clk,
  input logic                         rst_n,
  multicycle_main_control_if.master   bus
);
  state_t state_q, state_d;
  always_ff @(posedge clk)
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  // All strobes are forced low while in reset so nothing partial reaches the datapath.
  always_comb begin
    state_d            = state_q;
    bus.pc_write       = 1'b0;
    bus.pc_write_cond  = 1'b0;
    bus.i_or_d         = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.ir_write       = 1'b0;
    bus.mem_to_reg     = 1'b0;
    bus.reg_dst        = 1'b0;
    bus.reg_write      = 1'b0;
    bus.alu_src_a      = 1'b0;
    bus.alu_src_b      = SRCB_B;
    bus.alu_op         = ALUOP_ADD;
    bus.pc_source      = PCSRC_ALU;
    bus.illegal_op     = 1'b0;
    if (rst_n)
      case (state_q)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
          state_d       = bus.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          bus.alu_src_b = SRCB_IMM_SH;
          case (bus.opcode)
            OP_LW, OP_SW: state_d = MEM_ADDR;
            OP_RTYPE:     state_d = EXECUTE;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            default: begin
              state_d        = FETCH;
              bus.illegal_op = 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          state_d       = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        end
        MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          state_d      = bus.mem_ready ? MEM_WB : MEM_READ;
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          state_d        = FETCH;
        end
        MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          state_d       = bus.mem_ready ? FETCH : MEM_WRITE;
        end
        EXECUTE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALUOP_FUNCT;
          state_d       = R_COMPLETE;
        end
        R_COMPLETE: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
          state_d       = FETCH;
        end
        BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = ALUOP_SUB;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = PCSRC_ALUOUT;
          state_d           = FETCH;
        end
        JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = PCSRC_JUMP;
          state_d       = FETCH;
        end
        default: state_d = FETCH;
      endcase
  end
  assign bus.state_dbg = rst_n ? state_q : FETCH;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: directed cycle-by-cycle checks of every control output.
module tb_multicycle_main_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  multicycle_main_control_if bus ();
  multicycle_main_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // {state, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aluop, pcsrc, illegal}
  logic [20:0] obs;
  assign obs = {bus.state_dbg, bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
  localparam logic [20:0] E_RST = 21'd0;
  localparam logic [20:0] E_FW  = {4'd0, 10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_FG  = {4'd0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_DEC = {4'd1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_ILL = {4'd1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [20:0] E_MA  = {4'd2, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_MR  = {4'd3, 10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_WB  = {4'd4, 10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_MW  = {4'd5, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_EX  = {4'd6, 10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [20:0] E_RC  = {4'd7, 10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_BR  = {4'd8, 10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [20:0] E_JP  = {4'd9, 10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, BAD = 6'b111111;
  logic [20:0] sb_q[$];
  string       tag_q[$];
  task automatic cyc(input string tag, input logic rn, input logic [5:0] op, input logic mr,
                     input logic [20:0] e);
    logic [20:0] exp_v;
    string       t;
    rst_n         = rn;
    bus.opcode    = op;
    bus.mem_ready = mr;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    exp_v = sb_q.pop_front();
    t     = tag_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.opcode    = RT;
    bus.mem_ready = 1'b0;
    cyc("rst0", 1'b0, RT, 1'b1, E_RST);
    cyc("rst1", 1'b0, RT, 1'b1, E_RST);
    cyc("lw_f",  1'b1, LW, 1'b1, E_FG);
    cyc("lw_d",  1'b1, LW, 1'b1, E_DEC);
    cyc("lw_ma", 1'b1, LW, 1'b1, E_MA);
    cyc("lw_mr", 1'b1, LW, 1'b1, E_MR);
    cyc("lw_wb", 1'b1, LW, 1'b1, E_WB);
    cyc("r_f",   1'b1, RT, 1'b1, E_FG);
    cyc("r_d",   1'b1, RT, 1'b0, E_DEC);
    cyc("r_ex",  1'b1, RT, 1'b0, E_EX);
    cyc("r_rc",  1'b1, RT, 1'b0, E_RC);
    cyc("fw1",   1'b1, BQ, 1'b0, E_FW);
    cyc("fw2",   1'b1, BQ, 1'b0, E_FW);
    cyc("fw3",   1'b1, BQ, 1'b0, E_FW);
    cyc("fw_go", 1'b1, BQ, 1'b1, E_FG);
    cyc("bq_d",  1'b1, BQ, 1'b1, E_DEC);
    cyc("bq_br", 1'b1, BQ, 1'b1, E_BR);
    cyc("j_f",   1'b1, JP, 1'b1, E_FG);
    cyc("j_d",   1'b1, JP, 1'b1, E_DEC);
    cyc("j_jp",  1'b1, JP, 1'b1, E_JP);
    cyc("sw_f",  1'b1, SW, 1'b1, E_FG);
    cyc("sw_d",  1'b1, SW, 1'b1, E_DEC);
    cyc("sw_ma", 1'b1, SW, 1'b0, E_MA);
    cyc("sw_w1", 1'b1, SW, 1'b0, E_MW);
    cyc("sw_w2", 1'b1, SW, 1'b0, E_MW);
    cyc("sw_w3", 1'b1, SW, 1'b1, E_MW);
    cyc("il_f",  1'b1, BAD, 1'b1, E_FG);
    cyc("il_d",  1'b1, BAD, 1'b1, E_ILL);
    cyc("il_nf", 1'b1, LW, 1'b1, E_FG);
    cyc("rm_d",  1'b1, LW, 1'b1, E_DEC);
    cyc("rm_ma", 1'b1, LW, 1'b1, E_MA);
    cyc("rm_rst", 1'b0, LW, 1'b1, E_RST);
    cyc("rm_f",  1'b1, LW, 1'b1, E_FG);
    cyc("lww_d", 1'b1, LW, 1'b1, E_DEC);
    cyc("lww_ma", 1'b1, LW, 1'b1, E_MA);
    cyc("lww_w", 1'b1, LW, 1'b0, E_MR);
    cyc("lww_mr", 1'b1, LW, 1'b1, E_MR);
    cyc("lww_wb", 1'b1, LW, 1'b0, E_WB);
    cyc("end_f", 1'b1, RT, 1'b0, E_FW);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
